// File: rtl/fb_fetch_sched.sv
// fb_fetch_sched: refill scheduler for the display pixel FIFO.
//
// Watches the FIFO fill level and issues fixed-length burst read requests that
// walk the frame linearly. Words requested but not yet returned are counted so
// the FIFO can never be overrun. The framebuffer base is latched only when a
// request for frame offset 0 is issued, so buffer swaps never tear.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_n_i        synchronous active-low reset
//   enable_i       run fetching while high
//   base_addr_i    framebuffer start address, sampled at frame start
//   fifo_level_i   current FIFO occupancy
//   req_o          burst read request, held until req_ack_i
//   req_addr_o     start address of the requested burst
//   req_ack_i      burst accepted (one-cycle pulse)
//   rd_valid_i     one returned data word this cycle
//   fifo_wr_en_o   FIFO write strobe (combinational from rd_valid_i)
//   frame_start_o  one-cycle pulse after the first burst of a frame is accepted
//   busy_o         high whenever the scheduler is not idle
//   err_spurious_o sticky: a word arrived with nothing outstanding
//
// State | meaning
// IDLE  | fetching stopped, offset at frame top
// CHECK | waiting for FIFO space for one more burst
// REQ   | request presented, waiting for acknowledge
// DRAIN | disabled, waiting for in-flight words to return

module fb_fetch_sched #(
    parameter int ADDR_WIDTH  = 24,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 64,
    parameter int FRAME_WORDS = 76800,
    parameter int LEVEL_WIDTH = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [LEVEL_WIDTH-1:0] fifo_level_i,
    output logic                   req_o,
    output logic [ADDR_WIDTH-1:0]  req_addr_o,
    input  logic                   req_ack_i,
    input  logic                   rd_valid_i,
    output logic                   fifo_wr_en_o,
    output logic                   frame_start_o,
    output logic                   busy_o,
    output logic                   err_spurious_o
);

    localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int OUT_W = LEVEL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q;
    logic [OFF_W-1:0]        offset_q;
    logic [OUT_W-1:0]        outstanding_q;
    logic [OUT_W-1:0]        outstanding_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic                    req_q;
    logic                    frame_start_q;
    logic                    err_q;

    logic                    word_ok;
    logic                    ack_ok;
    logic                    space_ok;
    logic [OFF_W-1:0]        offset_d;
    logic [ADDR_WIDTH-1:0]   base_sel;
    int                      offset_inc;

    assign word_ok  = rd_valid_i && (outstanding_q != '0);
    assign ack_ok   = (state_q == REQ) && req_ack_i;

    // Evaluated in 32 bits so the sum can never wrap and fake free space.
    assign space_ok = (int'(fifo_level_i) + int'(outstanding_q) + BURST_LEN) <= FIFO_DEPTH;

    assign offset_inc = int'(offset_q) + BURST_LEN;
    assign offset_d   = (offset_inc >= FRAME_WORDS) ? '0 : OFF_W'(offset_inc);

    // At frame top the incoming base is used directly, since base_q is only
    // being loaded in the same cycle.
    assign base_sel = (offset_q == '0) ? base_addr_i : base_q;

    // Ack and a returned word in the same cycle fold into one update.
    always_comb begin
        outstanding_d = outstanding_q;
        if (ack_ok) begin
            outstanding_d = outstanding_d + OUT_W'(BURST_LEN);
        end
        if (word_ok) begin
            outstanding_d = outstanding_d - OUT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            offset_q      <= '0;
            outstanding_q <= '0;
            base_q        <= '0;
            req_addr_q    <= '0;
            req_q         <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            frame_start_q <= 1'b0;
            if (rd_valid_i && (outstanding_q == '0)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!enable_i) begin
                        state_q <= DRAIN;
                    end else if (space_ok) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        req_addr_q <= base_sel + ADDR_WIDTH'(offset_q);
                        if (offset_q == '0) begin
                            base_q <= base_addr_i;
                        end
                    end
                end
                REQ: begin
                    // A presented request is never withdrawn, even if disabled.
                    if (req_ack_i) begin
                        req_q         <= 1'b0;
                        frame_start_q <= (offset_q == '0);
                        offset_q      <= offset_d;
                        state_q       <= CHECK;
                    end
                end
                DRAIN: begin
                    if (outstanding_q == '0) begin
                        offset_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_o          = req_q;
    assign req_addr_o     = req_addr_q;
    assign fifo_wr_en_o   = word_ok;
    assign frame_start_o  = frame_start_q;
    assign busy_o         = (state_q != IDLE);
    assign err_spurious_o = err_q;

endmodule

// File: tb/tb_fb_fetch_sched.sv
// Directed bench for fb_fetch_sched with a short frame (FRAME_WORDS=32) so
// frame wrap and base re-latching occur within a few bursts.
module tb_fb_fetch_sched;

    localparam int AW = 24;
    localparam int BL = 8;
    localparam int FD = 64;
    localparam int FW = 32;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] fifo_level;
    logic          req;
    logic [AW-1:0] req_addr;
    logic          req_ack;
    logic          rd_valid;
    logic          fifo_wr_en;
    logic          frame_start;
    logic          busy;
    logic          err_spurious;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          fs;
    } exp_t;

    exp_t exp_q[$];

    fb_fetch_sched #(
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD),
        .FRAME_WORDS(FW),
        .LEVEL_WIDTH(LW)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .base_addr_i   (base_addr),
        .fifo_level_i  (fifo_level),
        .req_o         (req),
        .req_addr_o    (req_addr),
        .req_ack_i     (req_ack),
        .rd_valid_i    (rd_valid),
        .fifo_wr_en_o  (fifo_wr_en),
        .frame_start_o (frame_start),
        .busy_o        (busy),
        .err_spurious_o(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic fs);
        exp_t e;
        e.addr = a;
        e.fs   = fs;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected request per accepted handshake, then checks
    // the frame_start pulse on the following cycle.
    logic fs_pend = 1'b0;
    logic fs_exp  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (fs_pend) begin
            chk("frame_start", 32'(frame_start), 32'(fs_exp));
            fs_pend = 1'b0;
        end else begin
            chk("frame_start_quiet", 32'(frame_start), 32'd0);
        end
        if (rst_n && req && req_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: addr 0x%0h while no request expected", req_addr);
            end else begin
                e = exp_q.pop_front();
                chk("req_addr", 32'(req_addr), 32'(e.addr));
                fs_exp  = e.fs;
                fs_pend = 1'b1;
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req) chk("req_timeout", 32'(req), 32'd1);
    endtask

    task automatic ack_req(input int dly);
        wait_req();
        repeat (dly) begin
            @(posedge clk); #1;
        end
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
    endtask

    task automatic ret_word(input string name, input logic exp_wr);
        rd_valid = 1'b1;
        #1;
        chk(name, 32'(fifo_wr_en), 32'(exp_wr));
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        rst_n      = 1'b0;
        enable     = 1'b0;
        base_addr  = '0;
        fifo_level = '0;
        req_ack    = 1'b0;
        rd_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_req_addr", 32'(req_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_spurious), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        rst_n = 1'b1;

        // 8 bursts fill the FIFO budget; the short frame wraps after 4.
        base_addr = 24'h001000;
        enable    = 1'b1;
        push(24'h001000, 1'b1); push(24'h001008, 1'b0);
        push(24'h001010, 1'b0); push(24'h001018, 1'b0);
        push(24'h001000, 1'b1); push(24'h001008, 1'b0);
        push(24'h001010, 1'b0); push(24'h001018, 1'b0);
        for (int i = 0; i < 8; i++) ack_req(2);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (req) seen = 1'b1;
        end
        chk("full_no_req", 32'(seen), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);

        // 8 words return while the level rises: still no room.
        for (int i = 0; i < 8; i++) begin
            fifo_level = LW'(i + 1);
            ret_word("ret_t2", 1'b1);
        end
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (req) seen = 1'b1;
        end
        chk("level8_no_req", 32'(seen), 32'd0);
        fifo_level = '0;
        push(24'h001000, 1'b1);
        ack_req(1);

        // Disable and drain all 64 outstanding words.
        enable = 1'b0;
        for (int i = 0; i < 64; i++) ret_word("drain64", 1'b1);
        wait_idle();

        // Base change mid-frame only applies at the next frame top.
        base_addr = 24'h001000;
        enable    = 1'b1;
        push(24'h001000, 1'b1); push(24'h001008, 1'b0);
        push(24'h001010, 1'b0); push(24'h001018, 1'b0);
        push(24'h002000, 1'b1);
        ack_req(2);
        ack_req(2);
        base_addr = 24'h002000;
        ack_req(2);
        ack_req(2);
        wait_req();
        fifo_level = LW'(64);
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        for (int i = 0; i < 40; i++) ret_word("ret40", 1'b1);

        // Ack coinciding with a returned word: 8 + 8 - 1 = 15 outstanding.
        fifo_level = '0;
        push(24'h002008, 1'b0);
        ack_req(1);
        push(24'h002010, 1'b0);
        wait_req();
        req_ack    = 1'b1;
        rd_valid   = 1'b1;
        fifo_level = LW'(64);
        #1;
        chk("coinc_wr_en", 32'(fifo_wr_en), 32'd1);
        @(posedge clk); #1;
        req_ack  = 1'b0;
        rd_valid = 1'b0;
        for (int i = 0; i < 15; i++) ret_word("ret15", 1'b1);
        ret_word("spurious_wr_en", 1'b0);
        chk("err_set", 32'(err_spurious), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err_spurious), 32'd1);

        // Disable while the request is pending: it stays up until acked.
        fifo_level = '0;
        push(24'h002018, 1'b0);
        wait_req();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("req_held", 32'(req), 32'd1);
        end
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) ret_word("drain8", 1'b1);
        wait_idle();
        chk("err_still_set", 32'(err_spurious), 32'd1);

        base_addr = 24'h003000;
        enable    = 1'b1;
        push(24'h003000, 1'b1);
        ack_req(0);

        // Reset during an open request with words in flight.
        wait_req();
        rd_valid = 1'b1;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_addr", 32'(req_addr), 32'd0);
        chk("mid_rst_fs", 32'(frame_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_spurious), 32'd0);
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b0;
        #1;
        chk("post_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        chk("post_rst_err", 32'(err_spurious), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
